// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU types and width constants.
//   ptw_arb_state_t : page-table-walker arbiter FSM states
//   MMU_PTW_NUM_REQ : default number of PTW requesters (iTLB + dTLB)
//   VPN_W / PTE_RSP_W : walk request (VPN) and response (PTE + fault) widths
package mmu_pkg;
  localparam int MMU_PTW_NUM_REQ = 2;
  localparam int VPN_W           = 27;
  localparam int PTE_RSP_W       = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ptw_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational cyclic-priority picker.
//   eligible : request vector
//   rr_ptr   : highest-priority index this cycle
//   gnt_oh   : one-hot grant
//   gnt_idx  : binary index of the grant
//   gnt_vld  : any eligible bit set
//   conflict : grant made while more than one requester was eligible
// The wrap is an explicit compare against NUM_REQ, so any NUM_REQ works.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld,
  output logic               conflict
);
  int idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld     = 1'b1;
        gnt_idx     = IDX_W'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  // more than one bit set <=> clearing the lowest set bit leaves something
  assign conflict = gnt_vld && (|(eligible & (eligible - NUM_REQ'(1))));
endmodule

// File: rtl/mmu_ptw_arbiter.sv
// mmu_ptw_arbiter: N-requester front end to the single page table walker.
// Round-robin grant in IDLE, one walk outstanding, per-requester flush kills
// the walk owned by that requester (its response is dropped).
//   req_valid_i/req_data_i/req_ready_o : TLB walk requests (ready one-hot)
//   flush_i                            : per-requester kill
//   rsp_valid_o/rsp_data_o             : registered response, data broadcast
//   ptw_req_*/ptw_rsp_*                : single PTW port
//   busy_o                             : walk in progress
//   pmu_arb_conflict_o                 : grant with competing requesters
module mmu_ptw_arbiter
  import mmu_pkg::*;
#(
  parameter  int NUM_REQ = MMU_PTW_NUM_REQ,
  parameter  int REQ_W   = VPN_W,
  parameter  int RSP_W   = PTE_RSP_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*REQ_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       flush_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [RSP_W-1:0]         rsp_data_o,
  output logic                     ptw_req_valid_o,
  input  logic                     ptw_req_ready_i,
  output logic [REQ_W-1:0]         ptw_req_data_o,
  input  logic                     ptw_rsp_valid_i,
  input  logic [RSP_W-1:0]         ptw_rsp_data_i,
  output logic                     busy_o,
  output logic                     pmu_arb_conflict_o
);
  ptw_arb_state_t state_q, state_d;
  logic [IDX_W-1:0]              rr_ptr_q, gnt_idx_q;
  logic                          kill_q;
  logic [NUM_REQ-1:0][REQ_W-1:0] req_data;
  logic [NUM_REQ-1:0]            eligible, gnt_oh;
  logic [IDX_W-1:0]              gnt_idx;
  logic                          gnt_vld, arb_conflict, flush_gnt, accept;

  assign req_data  = req_data_i;
  assign eligible  = req_valid_i & ~flush_i;
  assign flush_gnt = flush_i[gnt_idx_q];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld),
    .conflict (arb_conflict)
  );

  // Grant is suppressed while reset is asserted so no requester sees a
  // handshake that the registers are about to discard.
  assign accept = (state_q == IDLE) && rstn_i && gnt_vld;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    req_ready_o        = '0;
    pmu_arb_conflict_o = 1'b0;
    ptw_req_valid_o    = 1'b0;
    busy_o             = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready_o        = accept ? gnt_oh : '0;
        pmu_arb_conflict_o = accept && arb_conflict;
        if (gnt_vld) state_d = ISSUE;
      end
      ISSUE: begin
        ptw_req_valid_o = 1'b1;
        // a flush racing the handshake still lets the walk go; WAIT drops it
        if (ptw_req_ready_i) state_d = WAIT;
        else if (flush_gnt)  state_d = IDLE;
      end
      WAIT: if (ptw_rsp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rr_ptr_q       <= '0;
      gnt_idx_q      <= '0;
      kill_q         <= 1'b0;
      ptw_req_data_o <= '0;
      rsp_data_o     <= '0;
      rsp_valid_o    <= '0;
    end else begin
      rsp_valid_o <= '0;
      case (state_q)
        IDLE: if (gnt_vld) begin
          gnt_idx_q      <= gnt_idx;
          ptw_req_data_o <= req_data[gnt_idx];
          rr_ptr_q       <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
        ISSUE: if (ptw_req_ready_i) kill_q <= flush_gnt;
        WAIT: begin
          if (ptw_rsp_valid_i) begin
            rsp_data_o             <= ptw_rsp_data_i;
            rsp_valid_o[gnt_idx_q] <= ~(kill_q | flush_gnt);
            kill_q                 <= 1'b0;
          end else begin
            kill_q <= kill_q | flush_gnt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmu_ptw_arbiter.sv
// Bench for mmu_ptw_arbiter with four requesters: directed cycle table,
// a fairness sequence, then randomized traffic against a transaction model.
module tb_mmu_ptw_arbiter;
  localparam int N  = 4;
  localparam int RW = 27;
  localparam int PW = 64;

  logic                 clk = 1'b0;
  logic                 rstn, prdy, prv;
  logic [N-1:0]         vld, fl;
  logic [N-1:0][RW-1:0] rdata;
  logic [PW-1:0]        pdata;
  logic [N-1:0]         req_ready, rsp_valid;
  logic [PW-1:0]        rsp_data;
  logic                 pv, busy, conf;
  logic [RW-1:0]        pd;

  always #5 clk = ~clk;

  mmu_ptw_arbiter #(.NUM_REQ(N), .REQ_W(RW), .RSP_W(PW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(vld), .req_data_i(rdata), .req_ready_o(req_ready),
    .flush_i(fl), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .ptw_req_valid_o(pv), .ptw_req_ready_i(prdy), .ptw_req_data_o(pd),
    .ptw_rsp_valid_i(prv), .ptw_rsp_data_i(pdata),
    .busy_o(busy), .pmu_arb_conflict_o(conf)
  );

  typedef struct {
    bit rs; logic [N-1:0] v, f; bit pr, pv; logic [PW-1:0] pd;
    logic [N-1:0] e_rdy; bit e_pv; logic [RW-1:0] e_pd;
    logic [N-1:0] e_rv; bit e_busy, e_conf; logic [PW-1:0] e_rd;
  } row_t;
  row_t tbl[$];
  row_t nul;

  int n_chk = 0, n_err = 0;

  // Walk-level model: phase 0 = no walk, 1 = request offered, 2 = awaiting PTW
  int            m_ph, m_ptr, m_gnt, m_rv;
  bit            m_kill;
  logic [RW-1:0] m_pd;
  logic [PW-1:0] m_rd;
  logic [N-1:0]  last_rdy;
  bit            last_conf;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_ptr = 0; m_gnt = 0; m_rv = -1; m_kill = 0; m_pd = '0; m_rd = '0;
  endtask

  function automatic int pick(input logic [N-1:0] el);
    for (int k = 0; k < N; k++)
      if (el[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Called just after the falling edge with inputs set; checks, advances the
  // model across the next rising edge, returns at the following falling edge.
  task automatic tick(input bit use_tbl, input row_t r);
    logic [N-1:0] el, er;
    int g;
    bit ec;
    #1;
    el = vld & ~fl;
    g  = (m_ph == 0 && rstn) ? pick(el) : -1;
    er = (g >= 0) ? N'(1 << g) : '0;
    ec = (g >= 0) && ($countones(el) > 1);
    last_rdy = er; last_conf = ec;
    chk("req_ready", req_ready, er);
    chk("conflict", conf, ec);
    chk("ptw_valid", pv, m_ph == 1);
    chk("ptw_data", pd, m_pd);
    chk("busy", busy, m_ph != 0);
    chk("rsp_valid", rsp_valid, (m_rv >= 0) ? 64'(1 << m_rv) : 64'd0);
    chk("rsp_data", rsp_data, m_rd);
    if (use_tbl) begin
      chk("tbl_ready", req_ready, r.e_rdy);
      chk("tbl_ptw_valid", pv, r.e_pv);
      chk("tbl_ptw_data", pd, r.e_pd);
      chk("tbl_rsp_valid", rsp_valid, r.e_rv);
      chk("tbl_busy", busy, r.e_busy);
      chk("tbl_conflict", conf, r.e_conf);
      chk("tbl_rsp_data", rsp_data, r.e_rd);
    end
    if (!rstn) model_reset();
    else begin
      m_rv = -1;
      case (m_ph)
        0: if (g >= 0) begin m_gnt = g; m_pd = rdata[g]; m_ptr = (g + 1) % N; m_ph = 1; end
        1: if (prdy) begin m_ph = 2; m_kill = fl[m_gnt]; end
           else if (fl[m_gnt]) m_ph = 0;
        default: if (prv) begin
             m_rd = pdata;
             if (!(m_kill || fl[m_gnt])) m_rv = m_gnt;
             m_kill = 0; m_ph = 0;
           end else m_kill = m_kill | fl[m_gnt];
      endcase
    end
    @(negedge clk);
  endtask

  task automatic add(input bit rs, input logic [N-1:0] v, f, input bit pr, pvv,
                     input logic [PW-1:0] pdd, input logic [N-1:0] erdy, input bit epv,
                     input logic [RW-1:0] epd, input logic [N-1:0] erv, input bit eb, ec,
                     input logic [PW-1:0] erd);
    tbl.push_back(row_t'{rs, v, f, pr, pvv, pdd, erdy, epv, epd, erv, eb, ec, erd});
  endtask

  initial begin
    for (int i = 0; i < N; i++) rdata[i] = RW'(27'h1230 + 2 * i);
    rstn = 0; vld = '0; fl = '0; prdy = 0; prv = 0; pdata = '0;
    model_reset();
    last_rdy = '0; last_conf = 0;
    @(posedge clk);
    @(negedge clk);

    //  rs  vld      flush    rdy prv pdata      | ready    pv pd       rv       bsy cf rsp_data
    add(0, 4'b0000, 4'b0000, 0, 0, 64'h0,      4'b0000, 0, 27'h0,    4'b0000, 0, 0, 64'h0);
    add(1, 4'b0100, 4'b0000, 0, 0, 64'h0,      4'b0100, 0, 27'h0,    4'b0000, 0, 0, 64'h0);
    add(1, 4'b0000, 4'b0000, 1, 0, 64'h0,      4'b0000, 1, 27'h1234, 4'b0000, 1, 0, 64'h0);
    for (int i = 0; i < 4; i++)
      add(1, 4'b0000, 4'b0000, 0, 0, 64'h0,    4'b0000, 0, 27'h1234, 4'b0000, 1, 0, 64'h0);
    add(1, 4'b0000, 4'b0000, 0, 1, 64'hABCD,   4'b0000, 0, 27'h1234, 4'b0000, 1, 0, 64'h0);
    add(1, 4'b0011, 4'b0000, 0, 0, 64'h0,      4'b0001, 0, 27'h1234, 4'b0100, 0, 1, 64'hABCD);
    add(1, 4'b0010, 4'b0000, 0, 0, 64'h0,      4'b0000, 1, 27'h1230, 4'b0000, 1, 0, 64'hABCD);
    add(1, 4'b0010, 4'b0001, 0, 0, 64'h0,      4'b0000, 1, 27'h1230, 4'b0000, 1, 0, 64'hABCD);
    add(1, 4'b0010, 4'b0000, 0, 1, 64'hDEAD,   4'b0010, 0, 27'h1230, 4'b0000, 0, 0, 64'hABCD);
    add(1, 4'b0000, 4'b0000, 1, 0, 64'h0,      4'b0000, 1, 27'h1232, 4'b0000, 1, 0, 64'hABCD);
    add(1, 4'b0000, 4'b0010, 0, 0, 64'h0,      4'b0000, 0, 27'h1232, 4'b0000, 1, 0, 64'hABCD);
    add(1, 4'b0000, 4'b0000, 0, 0, 64'h0,      4'b0000, 0, 27'h1232, 4'b0000, 1, 0, 64'hABCD);
    add(1, 4'b0000, 4'b0000, 0, 1, 64'h5555,   4'b0000, 0, 27'h1232, 4'b0000, 1, 0, 64'hABCD);
    add(1, 4'b0100, 4'b0000, 0, 0, 64'h0,      4'b0100, 0, 27'h1232, 4'b0000, 0, 0, 64'h5555);
    add(1, 4'b0000, 4'b0000, 1, 0, 64'h0,      4'b0000, 1, 27'h1234, 4'b0000, 1, 0, 64'h5555);
    add(1, 4'b0000, 4'b0000, 0, 0, 64'h0,      4'b0000, 0, 27'h1234, 4'b0000, 1, 0, 64'h5555);
    add(0, 4'b0000, 4'b0000, 0, 0, 64'h0,      4'b0000, 0, 27'h1234, 4'b0000, 1, 0, 64'h5555);
    add(1, 4'b0000, 4'b0000, 0, 1, 64'h7777,   4'b0000, 0, 27'h0,    4'b0000, 0, 0, 64'h0);
    add(1, 4'b1100, 4'b0000, 0, 0, 64'h0,      4'b0100, 0, 27'h0,    4'b0000, 0, 1, 64'h0);
    add(1, 4'b1000, 4'b0000, 1, 0, 64'h0,      4'b0000, 1, 27'h1234, 4'b0000, 1, 0, 64'h0);
    add(1, 4'b1000, 4'b0000, 0, 1, 64'h1111,   4'b0000, 0, 27'h1234, 4'b0000, 1, 0, 64'h0);
    add(1, 4'b1000, 4'b0000, 0, 0, 64'h0,      4'b1000, 0, 27'h1234, 4'b0100, 0, 0, 64'h1111);
    add(1, 4'b0000, 4'b0000, 1, 0, 64'h0,      4'b0000, 1, 27'h1236, 4'b0000, 1, 0, 64'h1111);
    add(1, 4'b0000, 4'b0000, 0, 1, 64'h2222,   4'b0000, 0, 27'h1236, 4'b0000, 1, 0, 64'h1111);
    add(1, 4'b0000, 4'b0000, 0, 0, 64'h0,      4'b0000, 0, 27'h1236, 4'b1000, 0, 0, 64'h2222);

    foreach (tbl[i]) begin
      rstn = tbl[i].rs; vld = tbl[i].v; fl = tbl[i].f;
      prdy = tbl[i].pr; prv = tbl[i].pv; pdata = tbl[i].pd;
      tick(1, tbl[i]);
    end

    // fairness: everyone held valid, pointer starts at 0 after the wrap above
    rstn = 1; vld = '1; fl = '0;
    for (int k = 0; k < 5; k++) begin
      prdy = 0; prv = 0;
      tick(0, nul);
      chk("fair_grant", last_rdy, 64'(1 << (k % 4)));
      chk("fair_conflict", last_conf, 1);
      prdy = 1;
      tick(0, nul);
      prdy = 0; prv = 1; pdata = 64'(k);
      tick(0, nul);
    end

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (vld[i] && last_rdy[i]) vld[i] = 1'b0;
        else if (vld[i] && $urandom_range(31) == 0) vld[i] = 1'b0;
        else if (!vld[i] && $urandom_range(3) == 0) begin
          vld[i] = 1'b1; rdata[i] = RW'($urandom);
        end
        fl[i] = ($urandom_range(9) == 0);
      end
      prdy  = $urandom_range(1);
      prv   = ($urandom_range(3) == 0);
      pdata = {$urandom, $urandom};
      rstn  = ($urandom_range(199) != 0);
      tick(0, nul);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
